mul_result_collector: RTL

MUL_RESULT_COLLECTOR -- requirements
Module: mul_result_collector

---
 rtl/mul_pkg.sv | 15 +
 rtl/result_fifo.sv | 60 ++++++
 rtl/mul_result_collector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared defaults and result record for the multiplier result collector
package mul_pkg;

    localparam int LATENCY_DEF = 4;
    localparam int DEPTH_DEF   = 8;
    localparam int PW_DEF      = 64;
    localparam int SEQ_W       = 8;

    typedef struct packed {
        logic [PW_DEF-1:0] data;
        logic              signedFlag;
        logic [SEQ_W-1:0]  seq;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous DEPTH-entry result queue with occupancy count
module result_fifo
    import mul_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = result_t
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       flush,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_result_collector.sv
// rtl/mul_result_collector.sv - tracks multiplier issues through a valid pipe and queues
// tagged products in issue order behind a credit-based issue handshake.
module mul_result_collector
    import mul_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PW      = PW_DEF
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             issueValid,
    input  logic             issueSigned,
    output logic             issueReady,
    input  logic [PW-1:0]    mulOut,
    input  logic             flush,
    output logic             resValid,
    input  logic             resReady,
    output logic [PW-1:0]    resData,
    output logic             resSigned,
    output logic [SEQ_W-1:0] resSeq,
    output logic             overflowErr
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(LATENCY+1);

    // Same layout as result_t, sized to this instance's product width.
    typedef struct packed {
        logic [PW-1:0]    data;
        logic             signedFlag;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    logic [LATENCY-1:0]            pipe_v;
    logic [LATENCY-1:0]            pipe_s;
    logic [LATENCY-1:0][SEQ_W-1:0] pipe_seq;
    logic [IW-1:0]                 in_flight;
    logic [SEQ_W-1:0]              seq_ctr;

    logic          accept;
    logic          push_req;
    logic          pop_req;
    entry_t        push_entry;
    entry_t        head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign accept   = issueValid && issueReady;
    assign push_req = pipe_v[LATENCY-1];
    assign pop_req  = resValid && resReady;

    // Credits count queued plus in-flight results, so an accepted issue always has a slot.
    assign issueReady = (int'(fifo_count) + int'(in_flight)) < DEPTH;

    assign push_entry.data       = mulOut;
    assign push_entry.signedFlag = pipe_s[LATENCY-1];
    assign push_entry.seq        = pipe_seq[LATENCY-1];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pipe_v    <= '0;
            pipe_s    <= '0;
            pipe_seq  <= '0;
            in_flight <= '0;
            seq_ctr   <= '0;
        end else if (flush) begin
            pipe_v    <= '0;
            pipe_s    <= '0;
            pipe_seq  <= '0;
            in_flight <= '0;
            seq_ctr   <= '0;
        end else begin
            for (int i = LATENCY-1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_s[i]   <= pipe_s[i-1];
                pipe_seq[i] <= pipe_seq[i-1];
            end
            pipe_v[0]   <= accept;
            pipe_s[0]   <= issueSigned;
            pipe_seq[0] <= seq_ctr;
            if (accept) seq_ctr <= seq_ctr + 1'b1;
            case ({accept, push_req})
                2'b10:   in_flight <= in_flight + IW'(1);
                2'b01:   in_flight <= in_flight - IW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflowErr <= 1'b0;
        end else if (push_req && fifo_full && !pop_req && !flush) begin
            overflowErr <= 1'b1;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .flush (flush),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop_req),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign resValid  = !fifo_empty;
    assign resData   = resValid ? head.data       : '0;
    assign resSigned = resValid ? head.signedFlag : 1'b0;
    assign resSeq    = resValid ? head.seq        : '0;

endmodule
